// File: rtl/burst_pkg.sv
// Shared types for the SPI burst datapath.
// Holds the FSM state encoding, default widths and word_sel codes.
package burst_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int BLEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        ARMED   = 2'd2,
        DONE    = 2'd3
    } burst_st_e;

    // Word selector shared with the burst controller and PTS.
    typedef enum logic [1:0] {
        WSEL_CMD  = 2'd0,
        WSEL_ADDR = 2'd1,
        WSEL_LEN  = 2'd2,
        WSEL_DATA = 2'd3
    } word_sel_e;

endpackage

// File: rtl/burst_addr_gen_if.sv
// Bus between burst controller (master) and burst_addr_gen (slave).
// Carries load strobes, step strobes, clear and the address/count outputs.
interface burst_addr_gen_if
    import burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BLEN_W = BLEN_W_DEF
) ();
    logic              load_len;
    logic [BLEN_W-1:0] burst_len_in;
    logic              load_addr;
    logic [ADDR_W-1:0] addr_in;
    logic              cnt_en;
    logic              add_en;
    logic              clear;
    logic [ADDR_W-1:0] addr_out;
    logic [BLEN_W-1:0] beat_cnt;
    logic              armed;
    logic              stop_signal;

    modport master (
        output load_len, burst_len_in,
        output load_addr, addr_in,
        output cnt_en, add_en, clear,
        input  addr_out, beat_cnt,
        input  armed, stop_signal
    );

    modport slave (
        input  load_len, burst_len_in,
        input  load_addr, addr_in,
        input  cnt_en, add_en, clear,
        output addr_out, beat_cnt,
        output armed, stop_signal
    );
endinterface

// File: rtl/burst_addr_inc.sv
// Combinational next-beat address: addr + STRIDE.
// Ports: addr (current), addr_nxt. BURST_PAGE_WRAP_EN wraps in-page.
module burst_addr_inc
    import burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int STRIDE = 1
`ifdef BURST_PAGE_WRAP_EN
    ,
    parameter int PAGE_W = 8
`endif
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_nxt
);
`ifdef BURST_PAGE_WRAP_EN
    localparam logic [PAGE_W-1:0] PSTEP = PAGE_W'(STRIDE);

    // Page number held, offset wraps inside the page.
    assign addr_nxt = {addr[ADDR_W-1:PAGE_W],
                       addr[PAGE_W-1:0] + PSTEP};
`else
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

    assign addr_nxt = addr + STEP;
`endif
endmodule

// File: rtl/burst_addr_gen.sv
// Burst address/beat-count datapath with explicit FSM.
// Ports: clk, rst (async high), bus (slave). Macro: BURST_PAGE_WRAP_EN.
module burst_addr_gen
    import burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BLEN_W = BLEN_W_DEF,
    parameter int STRIDE = 1
`ifdef BURST_PAGE_WRAP_EN
    ,
    parameter int PAGE_W = 8
`endif
) (
    input logic             clk,
    input logic             rst,
    burst_addr_gen_if.slave bus
);
    burst_st_e         state;
    logic [BLEN_W-1:0] len_reg;
    logic              len_ok;
    logic              addr_ok;
    logic [ADDR_W-1:0] addr_nxt;
    logic [BLEN_W-1:0] cnt_nxt;
    logic              step;
    logic              ld;
    logic              keep;
    logic              nl;
    logic              na;

    assign step = bus.cnt_en & bus.add_en;
    assign ld   = bus.load_len | bus.load_addr;
    // Only LOADING accumulates flags; elsewhere a load starts afresh.
    assign keep = (state == LOADING);
    assign nl   = bus.load_len | (len_ok & keep);
    assign na   = bus.load_addr | (addr_ok & keep);

    assign cnt_nxt = bus.beat_cnt + BLEN_W'(1);

    burst_addr_inc #(
        .ADDR_W (ADDR_W),
        .STRIDE (STRIDE)
`ifdef BURST_PAGE_WRAP_EN
        ,
        .PAGE_W (PAGE_W)
`endif
    ) u_inc (
        .addr     (bus.addr_out),
        .addr_nxt (addr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            len_reg         <= '0;
            len_ok          <= 1'b0;
            addr_ok         <= 1'b0;
            bus.addr_out    <= '0;
            bus.beat_cnt    <= '0;
            bus.armed       <= 1'b0;
            bus.stop_signal <= 1'b0;
        end else if (bus.clear) begin
            state           <= IDLE;
            len_ok          <= 1'b0;
            addr_ok         <= 1'b0;
            bus.beat_cnt    <= '0;
            bus.armed       <= 1'b0;
            bus.stop_signal <= 1'b0;
        end else if (ld) begin
            if (bus.load_len)
                len_reg <= bus.burst_len_in;
            if (bus.load_addr)
                bus.addr_out <= bus.addr_in;
            if (state == ARMED) begin
                // Reload mid-burst re-arms with the new value(s).
                bus.beat_cnt <= '0;
            end else begin
                len_ok          <= nl;
                addr_ok         <= na;
                bus.stop_signal <= 1'b0;
                if (nl && na) begin
                    state        <= ARMED;
                    bus.armed    <= 1'b1;
                    bus.beat_cnt <= '0;
                end else begin
                    state     <= LOADING;
                    bus.armed <= 1'b0;
                end
            end
        end else begin
            case (state)
                ARMED: begin
                    if (len_reg == '0) begin
                        state           <= DONE;
                        bus.armed       <= 1'b0;
                        bus.stop_signal <= 1'b1;
                    end else if (step) begin
                        bus.addr_out <= addr_nxt;
                        bus.beat_cnt <= cnt_nxt;
                        if (cnt_nxt == len_reg) begin
                            state           <= DONE;
                            bus.armed       <= 1'b0;
                            bus.stop_signal <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_addr_gen.sv
// Self-checking bench for burst_addr_gen.
// Table vectors, async-reset sequence, random run vs reference model.
module tb_burst_addr_gen;

    localparam int STRIDE = 1;

`ifdef BURST_PAGE_WRAP_EN
    localparam logic [23:0] X100 = 24'h000000;
    localparam logic [23:0] WS   = 24'h0012FF;
    localparam logic [23:0] W1   = 24'h001200;
    localparam logic [23:0] W2   = 24'h001201;
`else
    localparam logic [23:0] X100 = 24'h000100;
    localparam logic [23:0] WS   = 24'hFFFFFF;
    localparam logic [23:0] W1   = 24'h000000;
    localparam logic [23:0] W2   = 24'h000001;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    burst_addr_gen_if bus ();

    burst_addr_gen #(.STRIDE(STRIDE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        ll;
        logic [7:0]  len;
        logic        la;
        logic [23:0] addr;
        logic        ce;
        logic        ae;
        logic        clr;
        logic [23:0] ea;
        logic [7:0]  eb;
        logic        earm;
        logic        estop;
        string       nm;
    } vec_t;

    vec_t vt[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [23:0] m_addr;
    logic [7:0]  m_len;
    int          m_beats;
    bit          m_hl;
    bit          m_ha;
    bit          m_act;
    bit          m_stop;

    function automatic logic [23:0] next_addr(input logic [23:0] a);
`ifdef BURST_PAGE_WRAP_EN
        logic [7:0] lo;
        lo = 8'((int'(a[7:0]) + STRIDE) % 256);
        return {a[23:8], lo};
`else
        return 24'((longint'(a) + STRIDE) % (64'd1 << 24));
`endif
    endfunction

    task automatic add(input logic ll, input logic [7:0] len,
                       input logic la, input logic [23:0] addr,
                       input logic ce, input logic ae,
                       input logic clr, input logic [23:0] ea,
                       input logic [7:0] eb, input logic earm,
                       input logic estop, input string nm);
        vec_t v;
        v.ll = ll; v.len = len; v.la = la; v.addr = addr;
        v.ce = ce; v.ae = ae; v.clr = clr;
        v.ea = ea; v.eb = eb; v.earm = earm; v.estop = estop;
        v.nm = nm;
        vt.push_back(v);
    endtask

    task automatic drive(input logic ll, input logic [7:0] len,
                         input logic la, input logic [23:0] addr,
                         input logic ce, input logic ae,
                         input logic clr);
        bus.load_len     = ll;
        bus.burst_len_in = len;
        bus.load_addr    = la;
        bus.addr_in      = addr;
        bus.cnt_en       = ce;
        bus.add_en       = ae;
        bus.clear        = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [23:0] ea,
                         input logic [7:0] eb, input logic earm,
                         input logic estop);
        checks++;
        if (bus.addr_out !== ea || bus.beat_cnt !== eb ||
            bus.armed !== earm || bus.stop_signal !== estop) begin
            failures++;
            $display("FAIL %s: got addr=%h beat=%0d armed=%b stop=%b want addr=%h beat=%0d armed=%b stop=%b",
                     nm, bus.addr_out, bus.beat_cnt, bus.armed,
                     bus.stop_signal, ea, eb, earm, estop);
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 8'd0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_addr = '0; m_len = '0; m_beats = 0;
        m_hl = 0; m_ha = 0; m_act = 0; m_stop = 0;
    endtask

    task automatic model_step(input bit ll, input logic [7:0] len,
                              input bit la, input logic [23:0] addr,
                              input bit stp, input bit clr);
        if (clr) begin
            m_act = 0; m_stop = 0; m_hl = 0; m_ha = 0; m_beats = 0;
        end else if (ll || la) begin
            if (ll) m_len = len;
            if (la) m_addr = addr;
            if (m_act) begin
                m_beats = 0;
            end else begin
                if (m_stop) begin
                    m_hl = ll; m_ha = la;
                end else begin
                    m_hl = m_hl || ll; m_ha = m_ha || la;
                end
                m_stop = 0;
                if (m_hl && m_ha) begin
                    m_act = 1; m_beats = 0;
                end
            end
        end else if (m_act) begin
            if (m_len == 0) begin
                m_act = 0; m_stop = 1;
            end else if (stp) begin
                m_addr = next_addr(m_addr);
                m_beats++;
                if (m_beats == int'(m_len)) begin
                    m_act = 0; m_stop = 1;
                end
            end
        end
    endtask

    initial begin
        // Table: ll len la addr ce ae clr | addr beat armed stop
        add(1'b1, 8'd4, 1'b0, 24'h0,   1'b0, 1'b0, 1'b0, 24'h000000, 8'd0, 1'b0, 1'b0, "len4");
        add(1'b0, 8'd0, 1'b1, 24'h100, 1'b0, 1'b0, 1'b0, 24'h000100, 8'd0, 1'b1, 1'b0, "addr100");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h000101, 8'd1, 1'b1, 1'b0, "step1");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h000102, 8'd2, 1'b1, 1'b0, "step2");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h000103, 8'd3, 1'b1, 1'b0, "step3");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h000104, 8'd4, 1'b0, 1'b1, "step4_done");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h000104, 8'd4, 1'b0, 1'b1, "step5_ignored");
        add(1'b1, 8'd2, 1'b1, 24'hFE,  1'b0, 1'b0, 1'b0, 24'h0000FE, 8'd0, 1'b1, 1'b0, "both_loads");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h0000FF, 8'd1, 1'b1, 1'b0, "fe_step1");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, X100,       8'd2, 1'b0, 1'b1, "fe_step2");
        add(1'b1, 8'd3, 1'b0, 24'h0,   1'b0, 1'b0, 1'b0, X100,       8'd2, 1'b0, 1'b0, "done_reload");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, X100,       8'd2, 1'b0, 1'b0, "step_loading");
        add(1'b0, 8'd0, 1'b1, 24'h200, 1'b0, 1'b0, 1'b0, 24'h000200, 8'd0, 1'b1, 1'b0, "arm200");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b0, 1'b0, 24'h000200, 8'd0, 1'b1, 1'b0, "add_en_low");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h000201, 8'd1, 1'b1, 1'b0, "step201");
        add(1'b0, 8'd0, 1'b1, 24'h300, 1'b1, 1'b1, 1'b0, 24'h000300, 8'd0, 1'b1, 1'b0, "load_beats_step");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h000301, 8'd1, 1'b1, 1'b0, "step301");
        add(1'b1, 8'd9, 1'b0, 24'h0,   1'b1, 1'b1, 1'b1, 24'h000301, 8'd0, 1'b0, 1'b0, "clear_armed");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h000301, 8'd0, 1'b0, 1'b0, "step_idle");
        add(1'b1, 8'd0, 1'b1, 24'h50,  1'b0, 1'b0, 1'b0, 24'h000050, 8'd0, 1'b1, 1'b0, "zero_arm");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h000050, 8'd0, 1'b0, 1'b1, "zero_done");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b0, 1'b0, 1'b0, 24'h000050, 8'd0, 1'b0, 1'b1, "zero_hold");
        add(1'b1, 8'd2, 1'b1, WS,      1'b0, 1'b0, 1'b0, WS,         8'd0, 1'b1, 1'b0, "wrap_arm");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, W1,         8'd1, 1'b1, 1'b0, "wrap_step1");
        add(1'b0, 8'd0, 1'b0, 24'h0,   1'b1, 1'b1, 1'b0, W2,         8'd2, 1'b0, 1'b1, "wrap_step2");

        do_reset();
        check("reset", 24'h0, 8'd0, 1'b0, 1'b0);

        foreach (vt[i]) begin
            drive(vt[i].ll, vt[i].len, vt[i].la, vt[i].addr,
                  vt[i].ce, vt[i].ae, vt[i].clr);
            tick();
            check(vt[i].nm, vt[i].ea, vt[i].eb, vt[i].earm, vt[i].estop);
        end

        // Async reset mid-burst (beat 2 of 5)
        do_reset();
        drive(1'b1, 8'd5, 1'b1, 24'h10, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'd0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("pre_rst_beat2", 24'h12, 8'd2, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst", 24'h0, 8'd0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        #3 rst = 1'b0;
        tick();
        check("post_rst_idle", 24'h0, 8'd0, 1'b0, 1'b0);
        drive(1'b1, 8'd3, 1'b1, 24'h20, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'd0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("rearm_beat2", 24'h22, 8'd2, 1'b1, 1'b0);
        tick();
        check("rearm_done", 24'h23, 8'd3, 1'b0, 1'b1);

        // Random run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit          ll;
            bit          la;
            bit          ce;
            bit          ae;
            bit          clr;
            logic [7:0]  len;
            logic [23:0] addr;
            ll  = ($urandom_range(0, 11) == 0);
            la  = ($urandom_range(0, 11) == 0);
            clr = ($urandom_range(0, 59) == 0);
            ce  = ($urandom_range(0, 3) != 0);
            ae  = ($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                              : 8'($urandom_range(0, 6));
            addr = ($urandom_range(0, 3) == 0)
                   ? 24'(24'hFFFFF8 + $urandom_range(0, 7))
                   : 24'($urandom);
            drive(ll, len, la, addr, ce, ae, clr);
            tick();
            model_step(ll, len, la, addr, ce && ae, clr);
            check("random", m_addr, 8'(m_beats), m_act, m_stop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_addr_gen.md
Name: burst_addr_gen

Overview:
- Address and beat-count datapath driven by the burst controller in SPI burst mode.
- Latches the deserialised burst length and start address, then advances the address by STRIDE on each controller step strobe.
- Drives the parallel address into the address PTS serialiser and returns stop_signal to the controller when the programmed beat count is reached.
- Replaces ad-hoc counter/adder glue with one block that has an explicit FSM.

Parameters:
- ADDR_W, 24, address width in bits (3 SPI address bytes).
- BLEN_W, 8, burst length width in bits.
- STRIDE, 1, address increment per beat. Must be non-zero and less than 2^ADDR_W.
- PAGE_W, 8, log2 of the page size. Used only when BURST_PAGE_WRAP_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- load_len  in  1  one-cycle strobe; latch burst_len_in (driven by send_burst_len_data).
- burst_len_in  in  BLEN_W  parallel burst length from the burst-length STP.
- load_addr  in  1  one-cycle strobe; latch addr_in (driven by send_addr_data).
- addr_in  in  ADDR_W  parallel start address from the address STP.
- cnt_en  in  1  step strobe (counter_en).
- add_en  in  1  adder enable (adder_en). A step occurs only when cnt_en=1 and add_en=1.
- clear  in  1  synchronous abort; return to IDLE.
- addr_out  out  ADDR_W  current beat address to the PTS serialiser.
- beat_cnt  out  BLEN_W  number of steps taken since arming.
- armed  out  1  high in ARMED.
- stop_signal  out  1  high in DONE; feeds the controller.

Behaviour:
- Reset: state=IDLE; addr_out=0, beat_cnt=0, armed=0, stop_signal=0; internal len_reg=0, len_ok=0, addr_ok=0.
- Reset is honoured in any state, including mid-burst. All progress is lost; no partial stop is emitted.
- All outputs are registered. Effects of any input appear on the cycle after the sampling edge.
- FSM states: IDLE, LOADING, ARMED, DONE.
- IDLE:
  - load_len sets len_reg and len_ok.
  - load_addr sets addr_out=addr_in and addr_ok.
  - Exactly one strobe -> LOADING. Both strobes in the same cycle -> ARMED directly.
- LOADING: the missing strobe arrives -> ARMED. A repeated strobe of the already-loaded item overwrites the value and the state stays LOADING.
- Entering ARMED clears beat_cnt to 0. If len_reg==0, go to DONE on the next cycle: a zero-length burst stops immediately with no beats.
- ARMED, on a step:
  - addr_out <= addr_out + STRIDE, modulo 2^ADDR_W.
  - beat_cnt <= beat_cnt + 1.
  - If beat_cnt+1 == len_reg -> DONE.
- DONE:
  - stop_signal=1 and is held; steps are ignored; addr_out and beat_cnt freeze.
  - load_len or load_addr clears the other flag, drops stop_signal and behaves as in IDLE.
- clear, from any state -> IDLE next cycle. It zeros beat_cnt, stop_signal, len_ok and addr_ok; addr_out keeps its value.
- Simultaneous events:
  - A load strobe and a step in the same cycle: the load wins and the step is dropped.
  - clear beats load, and load beats step.
- A step in IDLE or LOADING is ignored, with no address change.
- beat_cnt never exceeds len_reg. The maximum burst is 2^BLEN_W - 1 beats.

Optional Feature:
- Macro: BURST_PAGE_WRAP_EN.
- Defined: increments wrap inside the 2^PAGE_W-byte page. Upper bits [ADDR_W-1:PAGE_W] are held; only the low PAGE_W bits add STRIDE modulo 2^PAGE_W. This matches MRAM page-burst semantics.
- Undefined: linear increment with full ADDR_W wrap (0xFFFFFF + 1 -> 0x000000). PAGE_W is unused.

Decomposition:
- Shared package burst_pkg holds:
  - the state encoding (IDLE=2'd0, LOADING=2'd1, ARMED=2'd2, DONE=2'd3);
  - default ADDR_W/BLEN_W constants;
  - the word_sel encoding shared with the controller and PTS.
- One sub-module, burst_addr_inc: combinational next-address (addr, STRIDE, and the page-wrap logic under the macro). It is isolated so the wrap rule can be verified standalone.
- The FSM and counters stay in the top module.

Test Plan:
- load_len=4, load_addr=0x000100 in separate cycles, then 4 steps -> addr_out goes 0x100, 0x101, 0x102, 0x103, 0x104; stop_signal rises the cycle after the 4th step; a 5th step changes nothing.
- Both loads in the same cycle (len=2, addr=0x0000FE) -> armed next cycle; 2 steps -> addr_out=0x000100; stop_signal=1.
- len=0 -> stop_signal=1 two cycles after arming; beat_cnt=0; addr_out unchanged.
- Start 0xFFFFFF, len=2, no macro -> addr_out goes 0x000000, then 0x000001. With BURST_PAGE_WRAP_EN, start 0x0012FF -> 0x001200, then 0x001201.
- Step coincident with load_addr, and cnt_en=1 with add_en=0 -> step dropped, no increment; clear during ARMED -> IDLE, stop_signal=0, beat_cnt=0.
- rst asserted asynchronously mid-burst (beat 2 of 5) -> all outputs read 0 before the next clk edge; after release, a full 3-beat burst completes normally.
